audio_event_sequencer: RTL



---
 rtl/audio_pkg.sv | 30 +++
 rtl/tone_gen.sv | 78 +++++++
 rtl/audio_event_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and default constants for the audio event
//               sequencer: playback state encoding, default channel
//               assignment and default per-channel half-periods (50 MHz clk).
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  // Playback state: silent and waiting, or generating a tone.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // Default channel assignment (higher index = higher priority).
  localparam int CH_JUMP  = 0;
  localparam int CH_WIN   = 1;
  localparam int CH_LOSE  = 2;
  localparam int CH_SPARE = 3;

  // Default half-periods in clk cycles at 50 MHz.
  localparam logic [15:0] HP_JUMP  = 16'd56818;  // ~440 Hz
  localparam logic [15:0] HP_WIN   = 16'd37936;  // ~659 Hz
  localparam logic [15:0] HP_LOSE  = 16'd63776;  // ~392 Hz
  localparam logic [15:0] HP_SPARE = 16'd0;      // muted

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_gen
// Description : Square-wave tone generator. Latches a half-period on load,
//               counts it down while enabled and toggles the output at each
//               phase reload. A half-period of zero mutes the output.
//               Optional macro AUDIO_SWEEP_EN adds a saturating half-period
//               increment input for falling-pitch sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_gen #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,   // new grant: latch hp_i, restart phase
  input  logic            clr_i,    // playback finishing: force silence
  input  logic            en_i,     // ordinary play cycle
`ifdef AUDIO_SWEEP_EN
  input  logic            sweep_i,  // bump latched half-period by one
`endif
  input  logic [HP_W-1:0] hp_i,
  output logic            sound_o
);

  localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

  logic [HP_W-1:0] hp_q, hp_d;
  logic [HP_W-1:0] phase_q, phase_d;
  logic            sound_q, sound_d;

  // Next-state: load beats clear beats normal counting.
  always_comb begin
    hp_d    = hp_q;
    phase_d = phase_q;
    sound_d = sound_q;
    if (load_i) begin
      hp_d    = hp_i;
      // A muted channel keeps the phase counter parked at zero rather than wrapping.
      phase_d = (hp_i == '0) ? '0 : (hp_i - HP_ONE);
      sound_d = (hp_i != '0);
    end else if (clr_i) begin
      sound_d = 1'b0;
    end else if (en_i) begin
      if (hp_q == '0) begin
        sound_d = 1'b0;
      end else if (phase_q == '0) begin
        sound_d = ~sound_q;
        phase_d = hp_q - HP_ONE;
      end else begin
        phase_d = phase_q - HP_ONE;
      end
    end
`ifdef AUDIO_SWEEP_EN
    // The reload above used the old hp; the bumped value applies from the next reload.
    if (!load_i && sweep_i && (hp_q != '1)) begin
      hp_d = hp_q + HP_ONE;
    end
`endif
  end

  // Tone state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hp_q    <= '0;
      phase_q <= '0;
      sound_q <= 1'b0;
    end else begin
      hp_q    <= hp_d;
      phase_q <= phase_d;
      sound_q <= sound_d;
    end
  end

  assign sound_o = sound_q;

endmodule
`default_nettype wire

// File: rtl/audio_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_event_sequencer
// Description : Edge-detects NUM_CH game-event triggers, grants the highest
//               index (with preemption/retrigger while playing) and plays a
//               per-channel square tone for DURATION cycles, then pulses done.
//               Optional macro AUDIO_SWEEP_EN enables per-channel pitch sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_event_sequencer
  import audio_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                HP_W       = 16,
  parameter int                DURATION   = 25000000,
  parameter int                SWEEP_STEP = 65536,
  parameter logic [NUM_CH-1:0] SWEEP_MASK = NUM_CH'(4'b0100),
  localparam int               CH_W       = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      trigger,
  input  logic [NUM_CH*HP_W-1:0] half_period,
  output logic                   sound,
  output logic                   busy,
  output logic [CH_W-1:0]        active_ch,
  output logic                   done
);

  localparam int              DUR_W    = $clog2(DURATION + 1);
  localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(DURATION - 1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] edges;
  logic [CH_W-1:0]   win;
  logic [HP_W-1:0]   win_hp;
  logic              any_edge;
  logic              grant;
  logic              last_cycle;
  logic              tone_en;

  state_e            state_q;
  logic              busy_q;
  logic [CH_W-1:0]   active_ch_q;
  logic [DUR_W-1:0]  dur_q;
  logic              done_q;

  // Trigger history for rising-edge detection; cleared so a held trigger fires after reset.
  always_ff @(posedge clk) begin
    if (reset) trig_q <= '0;
    else       trig_q <= trigger;
  end

  assign edges = trigger & ~trig_q;

  // Priority encoder: the highest set edge wins and selects its half-period.
  always_comb begin
    win      = '0;
    win_hp   = '0;
    any_edge = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (edges[i]) begin
        win      = CH_W'(i);
        win_hp   = half_period[i*HP_W +: HP_W];
        any_edge = 1'b1;
      end
    end
  end

  // Lower-priority edges during playback are dropped; equal index retriggers.
  assign grant      = any_edge && ((state_q == ST_IDLE) || (win >= active_ch_q));
  assign tone_en    = (state_q == ST_PLAY) && !grant;
  assign last_cycle = tone_en && (dur_q == '0);

  // Playback FSM with duration counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      active_ch_q <= '0;
      dur_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (grant) begin
        state_q     <= ST_PLAY;
        busy_q      <= 1'b1;
        active_ch_q <= win;
        dur_q       <= DUR_LOAD;
      end else if (state_q == ST_PLAY) begin
        if (dur_q == '0) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          dur_q <= dur_q - DUR_ONE;
        end
      end
    end
  end

`ifdef AUDIO_SWEEP_EN
  localparam int               SW_W    = (SWEEP_STEP > 1) ? $clog2(SWEEP_STEP) : 1;
  localparam logic [SW_W-1:0]  SW_LAST = SW_W'(SWEEP_STEP - 1);
  localparam logic [SW_W-1:0]  SW_ONE  = SW_W'(1);

  logic [SW_W-1:0] sweep_cnt_q;
  logic            sweep_tick;

  assign sweep_tick = tone_en && (sweep_cnt_q == SW_LAST) && SWEEP_MASK[active_ch_q];

  // Sweep interval counter: restarts on every grant, free-runs during play.
  always_ff @(posedge clk) begin
    if (reset || grant) begin
      sweep_cnt_q <= '0;
    end else if (tone_en) begin
      sweep_cnt_q <= (sweep_cnt_q == SW_LAST) ? '0 : (sweep_cnt_q + SW_ONE);
    end
  end
`endif

  tone_gen #(
    .HP_W (HP_W)
  ) u_tone (
    .clk     (clk),
    .reset   (reset),
    .load_i  (grant),
    .clr_i   (last_cycle),
    .en_i    (tone_en),
`ifdef AUDIO_SWEEP_EN
    .sweep_i (sweep_tick),
`endif
    .hp_i    (win_hp),
    .sound_o (sound)
  );

  assign busy      = busy_q;
  assign active_ch = active_ch_q;
  assign done      = done_q;

endmodule
`default_nettype wire
